// File: rtl/systolic_feeder.sv
// Upstream sequencer for the 2x2 systolic array: weight registers, input-vector
// FIFO, skewed operand/start issue and per-vector result capture.
module systolic_feeder #(
  parameter int DATA_W    = 16,
  parameter int VEC_DEPTH = 8,
  parameter int PE_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_we,
  input  logic [1:0]        w_sel,
  input  logic [DATA_W-1:0] w_data,
  input  logic              v_valid,
  output logic              v_ready,
  input  logic [DATA_W-1:0] v_x1,
  input  logic [DATA_W-1:0] v_x2,
  input  logic              go,
  output logic              busy,
  output logic [DATA_W-1:0] a11,
  output logic [DATA_W-1:0] a12,
  output logic [DATA_W-1:0] a21,
  output logic [DATA_W-1:0] a22,
  output logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] b2,
  output logic [DATA_W-1:0] prev_operand,
  output logic              start_PE11,
  output logic              start_PE12,
  output logic              start_PE21,
  output logic              start_PE22,
  output logic              clear,
  input  logic [DATA_W-1:0] result_row1,
  input  logic [DATA_W-1:0] result_row2,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_y1,
  output logic [DATA_W-1:0] res_y2
);

  localparam int AW      = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1;
  localparam int CW      = AW + 1;
  localparam int SH_LEN  = 3 + PE_LAT;
  localparam int Y1_TAP  = 1 + PE_LAT;
  localparam int OUT_TAP = 2 + PE_LAT;

  typedef enum logic [1:0] {IDLE, CLR, ISSUE, DRAIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem_x1 [VEC_DEPTH];
  logic [DATA_W-1:0] mem_x2 [VEC_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              push;
  logic              pop;
  logic [SH_LEN-1:0] iss_sh;
  logic [DATA_W-1:0] x2_pend;
  logic [DATA_W-1:0] y1_hold;

  // A full FIFO still accepts a push in a cycle where it is also popping.
  assign pop     = (state == ISSUE) && (count != '0);
  assign v_ready = (count != CW'(VEC_DEPTH)) || pop;
  assign push    = v_valid && v_ready;

  assign prev_operand = '0;

  // iss_sh[k] is high k cycles after a vector's first-stage cycle.
  assign start_PE11 = iss_sh[0];
  assign start_PE12 = iss_sh[1];
  assign start_PE21 = iss_sh[1];
  assign start_PE22 = iss_sh[2];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (!push && pop)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x1[wr_ptr] <= v_x1;
      mem_x2[wr_ptr] <= v_x2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      clear     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      a11       <= '0;
      a12       <= '0;
      a21       <= '0;
      a22       <= '0;
      b1        <= '0;
      b2        <= '0;
      x2_pend   <= '0;
      iss_sh    <= '0;
      y1_hold   <= '0;
      res_valid <= 1'b0;
      res_y1    <= '0;
      res_y2    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;

      if (w_we && state == IDLE) begin
        case (w_sel)
          2'd0:    a11 <= w_data;
          2'd1:    a12 <= w_data;
          2'd2:    a21 <= w_data;
          default: a22 <= w_data;
        endcase
      end

      // x2 trails x1 by one cycle to give the array its skew.
      iss_sh <= {iss_sh[SH_LEN-2:0], pop};
      if (pop) begin
        b1      <= mem_x1[rd_ptr];
        x2_pend <= mem_x2[rd_ptr];
      end
      if (iss_sh[0])
        b2 <= x2_pend;

      if (iss_sh[Y1_TAP])
        y1_hold <= result_row1;
      res_valid <= iss_sh[OUT_TAP];
      if (iss_sh[OUT_TAP]) begin
        res_y1 <= y1_hold;
        res_y2 <= result_row2;
      end

      clear <= 1'b0;
      case (state)
        IDLE: begin
          if (go && count != '0) begin
            state <= CLR;
            busy  <= 1'b1;
            clear <= 1'b1;
          end
        end
        CLR: state <= ISSUE;
        ISSUE: begin
          if (count_next == '0)
            state <= DRAIN;
        end
        default: begin
          // The last result beat is on the outputs once the shift line empties.
          if (iss_sh == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural 2x2 array model
// feeding result_row1/result_row2 back at the expected latency.
module tb_systolic_feeder;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int PE_LAT = 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              w_we = 1'b0;
  logic [1:0]        w_sel = '0;
  logic [DATA_W-1:0] w_data = '0;
  logic              v_valid = 1'b0;
  logic              v_ready;
  logic [DATA_W-1:0] v_x1 = '0;
  logic [DATA_W-1:0] v_x2 = '0;
  logic              go = 1'b0;
  logic              busy;
  logic [DATA_W-1:0] a11, a12, a21, a22, b1, b2, prev_operand;
  logic              start_PE11, start_PE12, start_PE21, start_PE22, clear;
  logic [DATA_W-1:0] result_row1 = '0;
  logic [DATA_W-1:0] result_row2 = '0;
  logic              res_valid;
  logic [DATA_W-1:0] res_y1, res_y2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_W(DATA_W), .VEC_DEPTH(DEPTH), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .reset(reset_n),
    .w_we(w_we), .w_sel(w_sel), .w_data(w_data),
    .v_valid(v_valid), .v_ready(v_ready), .v_x1(v_x1), .v_x2(v_x2),
    .go(go), .busy(busy),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22),
    .b1(b1), .b2(b2), .prev_operand(prev_operand),
    .start_PE11(start_PE11), .start_PE12(start_PE12),
    .start_PE21(start_PE21), .start_PE22(start_PE22),
    .clear(clear),
    .result_row1(result_row1), .result_row2(result_row2),
    .res_valid(res_valid), .res_y1(res_y1), .res_y2(res_y2)
  );

  // Array model: row1 of the vector started at cycle t is presented during
  // t+1+PE_LAT, row2 during t+2+PE_LAT.
  logic [DATA_W-1:0] x1_rec [64];
  logic [DATA_W-1:0] x2_rec [64];
  int unsigned mcyc = 100;
  always @(posedge clk) begin
    int unsigned i1, i2;
    #1;
    mcyc = mcyc + 1;
    if (start_PE11) x1_rec[mcyc & 63] = b1;
    if (start_PE12) x2_rec[(mcyc - 1) & 63] = b2;
    i1 = (mcyc - 1 - PE_LAT) & 63;
    i2 = (mcyc - 2 - PE_LAT) & 63;
    result_row1 = a11 * x1_rec[i1] + a12 * x2_rec[i1];
    result_row2 = a21 * x1_rec[i2] + a22 * x2_rec[i2];
  end

  // Result monitor: one entry and one printed line per result beat.
  logic [DATA_W-1:0] ry1 [64];
  logic [DATA_W-1:0] ry2 [64];
  int                rcyc [64];
  logic              rbusy [64];
  int nres = 0;
  int mon_cyc = 0;
  always @(posedge clk) begin
    #1;
    mon_cyc = mon_cyc + 1;
    if (res_valid && nres < 64) begin
      ry1[nres] = res_y1;
      ry2[nres] = res_y2;
      rcyc[nres] = mon_cyc;
      rbusy[nres] = busy;
      $display("result beat %0d: y1=%0d y2=%0d cycle=%0d", nres, res_y1, res_y2, mon_cyc);
      nres = nres + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic write_w(input logic [1:0] sel, input logic [DATA_W-1:0] val);
    w_we = 1'b1; w_sel = sel; w_data = val;
    tick(1);
    w_we = 1'b0;
  endtask

  task automatic push(input int x1, input int x2);
    v_valid = 1'b1; v_x1 = DATA_W'(x1); v_x2 = DATA_W'(x2);
    tick(1);
    v_valid = 1'b0;
  endtask

  task automatic start_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick(1);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_run(input string tag, input int base, input int nexp,
                           input int x1_0, input int x2_0);
    int last;
    check({tag, "_count"}, nres - base, nexp);
    for (int k = 0; k < nexp; k++) begin
      check({tag, "_y1"}, ry1[base + k], (x1_0 + k) * 1 + (x2_0 + k) * 2);
      check({tag, "_y2"}, ry2[base + k], (x1_0 + k) * 3 + (x2_0 + k) * 4);
      check({tag, "_b2b"}, rcyc[base + k] - rcyc[base], k);
    end
    last = base + nexp - 1;
    check({tag, "_busy_last"}, rbusy[last], 1);
    check({tag, "_busy_drop"}, mon_cyc - rcyc[last], 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // 1: reset state, go with an empty FIFO
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("rst_weights", {a11, a12, a21, a22}, 0);
    check("rst_b", {b1, b2, prev_operand}, 0);
    check("rst_starts", {start_PE11, start_PE12, start_PE21, start_PE22, clear}, 0);
    check("rst_res", {res_valid, res_y1, res_y2}, 0);
    check("rst_ready", v_ready, 1);
    check("rst_busy", busy, 0);
    start_go();
    check("empty_go_busy", busy, 0);
    tick(1);
    check("empty_go_busy2", {busy, clear}, 0);

    // 2: single vector, cycle-exact skew and result
    write_w(2'd0, 16'd7);
    write_w(2'd0, 16'd1);
    write_w(2'd1, 16'd2);
    write_w(2'd2, 16'd3);
    write_w(2'd3, 16'd4);
    check("w_last_wins", {a11, a12, a21, a22}, {16'd1, 16'd2, 16'd3, 16'd4});
    push(5, 6);
    base = nres;
    start_go();
    check("t2_clear", {clear, busy}, 2'b11);
    check("t2_clr_starts", {start_PE11, start_PE12, start_PE21, start_PE22}, 4'b0000);
    tick(1);
    check("t2_issue", {clear, start_PE11, start_PE12, start_PE21, start_PE22}, 0);
    tick(1);
    check("t2_start_t", {start_PE11, start_PE12, start_PE21, start_PE22}, 4'b1000);
    check("t2_b1", b1, 5);
    tick(1);
    check("t2_start_t1", {start_PE11, start_PE12, start_PE21, start_PE22}, 4'b0110);
    check("t2_b2", b2, 6);
    tick(1);
    check("t2_start_t2", {start_PE11, start_PE12, start_PE21, start_PE22}, 4'b0001);
    tick(1);
    check("t2_no_res_yet", res_valid, 0);
    tick(1);
    check("t2_res_valid", {res_valid, busy}, 2'b11);
    check("t2_y", {res_y1, res_y2}, {16'd17, 16'd39});
    tick(1);
    check("t2_done", {res_valid, busy}, 2'b00);
    check("t2_count", nres - base, 1);

    // 3: fill the FIFO, stream 8 back-to-back results
    for (int i = 0; i < 8; i++) begin
      check("t3_ready_before_push", v_ready, 1);
      push(10 + i, 20 + i);
    end
    check("t3_full", v_ready, 0);
    base = nres;
    start_go();
    wait_idle("t3");
    check_run("t3", base, 8, 10, 20);
    check("t3_empty_ready", v_ready, 1);

    // 4: push into a full FIFO in the same cycle as the first pop
    for (int i = 0; i < 8; i++) push(30 + i, 40 + i);
    base = nres;
    start_go();
    tick(1);
    check("t4_ready_full_pop", v_ready, 1);
    push(38, 48);
    wait_idle("t4");
    check_run("t4", base, 9, 30, 40);

    // 5: asynchronous reset during ISSUE after 3 pops
    for (int i = 0; i < 8; i++) push(50 + i, 60 + i);
    base = nres;
    start_go();
    tick(4);
    #1 reset_n = 1'b0;
    #1;
    check("t5_async_busy", busy, 0);
    check("t5_async_ready", v_ready, 1);
    check("t5_async_weights", {a11, a12, a21, a22}, 0);
    check("t5_async_outs", {start_PE11, start_PE12, start_PE22, b1, b2, res_valid}, 0);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    check("t5_no_res", nres - base, 0);
    check("t5_busy", busy, 0);
    start_go();
    check("t5_fifo_empty", {busy, clear}, 0);

    // 6: weight writes while busy are ignored
    write_w(2'd0, 16'd1);
    write_w(2'd1, 16'd2);
    write_w(2'd2, 16'd3);
    write_w(2'd3, 16'd4);
    push(2, 3);
    push(3, 4);
    base = nres;
    start_go();
    for (int i = 0; i < 4; i++) begin
      w_we = 1'b1; w_sel = 2'(i); w_data = 16'(90 + i);
      tick(1);
    end
    w_we = 1'b0;
    check("t6_busy_during_we", busy, 1);
    check("t6_weights_kept", {a11, a12, a21, a22}, {16'd1, 16'd2, 16'd3, 16'd4});
    wait_idle("t6");
    check_run("t6", base, 2, 2, 3);
    check("t6_weights_after", {a11, a12, a21, a22}, {16'd1, 16'd2, 16'd3, 16'd4});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
